muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing a 64-bit HI/LO result.
// Takes WIDTH steps after the start edge, then gives a one-cycle HI/LO write strobe.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic             busy,
  output logic             HiWrite,
  output logic             LoWrite,
  output logic [WIDTH-1:0] hi_data_in,
  output logic [WIDTH-1:0] lo_data_in
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             write_reg;

  // Operand capture: signed ops (op[0]==0) are converted to magnitudes
  logic             is_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs_data[WIDTH-1];
  assign b_neg     = is_signed & rt_data[WIDTH-1];
  assign b_zero    = (rt_data == '0);
  assign a_mag     = a_neg ? -rs_data : rs_data;
  assign b_mag     = b_neg ? -rt_data : rt_data;

  // Multiply step: acc_lo holds the multiplier, shifted out as product bits enter
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};

  // Restoring divide step: acc_lo holds dividend bits, shifted out as quotient bits enter
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_hi, div_lo;

  assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
  assign div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo    = {acc_lo_reg[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] step_prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               last_step;

  assign step_hi   = is_div_reg ? div_hi : mul_hi;
  assign step_lo   = is_div_reg ? div_lo : mul_lo;
  assign step_prod = {step_hi, step_lo};
  assign prod_fix  = neg_q_reg ? -step_prod : step_prod;
  assign last_step = (count_reg == CW'(WIDTH - 1));

  // Divide by zero leaves an all-ones quotient (neg_q cleared) and |a| remainder,
  // which the remainder sign fix turns back into the captured dividend.
  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      fix_hi = neg_r_reg ? -step_hi : step_hi;
      fix_lo = neg_q_reg ? -step_lo : step_lo;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        if (cancel)         state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      opnd_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      write_reg  <= 1'b0;
    end else begin
      write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= op[1] ? a_mag : b_mag;
            opnd_reg   <= op[1] ? b_mag : a_mag;
            is_div_reg <= op[1];
            neg_q_reg  <= (a_neg ^ b_neg) & ~(op[1] & b_zero);
            neg_r_reg  <= a_neg;
          end
        end
        CALC: begin
          if (!cancel) begin
            acc_hi_reg <= step_hi;
            acc_lo_reg <= step_lo;
            count_reg  <= count_reg + CW'(1);
            if (last_step) begin
              hi_reg    <= fix_hi;
              lo_reg    <= fix_lo;
              write_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign HiWrite    = write_reg;
  assign LoWrite    = write_reg;
  assign hi_data_in = hi_reg;
  assign lo_data_in = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pushed at issue, checked when the strobe fires.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         cancel = 1'b0;
  logic         busy, HiWrite, LoWrite;
  logic [W-1:0] hi_data_in, lo_data_in;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [63:0] res;
  } exp_t;
  exp_t        sb_q[$];
  logic [63:0] last_res = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .busy(busy), .HiWrite(HiWrite), .LoWrite(LoWrite),
    .hi_data_in(hi_data_in), .lo_data_in(lo_data_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      MULT:  return 64'(sa * sb);
      MULTU: return 64'(ua * ub);
      DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
    endcase
  endfunction

  // Scoreboard side: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (HiWrite || LoWrite) begin
      chk("strobe_pair", {63'd0, LoWrite}, {63'd0, HiWrite});
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_strobe: got hi=%h lo=%h, want no strobe", hi_data_in, lo_data_in);
      end
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk(e.tag, {hi_data_in, lo_data_in}, e.res);
      end
    end
  end

  // Drives one request for a cycle; returns just after the accepting edge
  task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [63:0] exp);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (push) begin
      sb_q.push_back('{tag, exp});
      last_res = exp;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
    chk({tag, "_busy_up"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_strobe(input string tag);
    int edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!HiWrite && edges < 40);
    chk({tag, "_latency"}, 64'(edges), 64'd32);
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic finish_op(input string tag);
    @(posedge clk); #1;
    chk({tag, "_strobe_1cyc"}, {63'd0, HiWrite}, 64'd0);
    chk({tag, "_busy_down"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    issue(tag, o, a, b, 1'b1, exp);
    wait_strobe(tag);
    finish_op(tag);
  endtask

  initial begin
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_strobes", {62'd0, HiWrite, LoWrite}, 64'd0);
    chk("reset_data", {hi_data_in, lo_data_in}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("mult_neg3x7", MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    run_op("mult_minmin", MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu_by0", DIVU, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    run_op("div_by0", DIV, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    run_op("div_neg_by0", DIV, 32'hF0000001, 32'd0, 64'hF0000001_FFFFFFFF);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // start held high with changing operands through the whole operation
    issue("repulse", MULTU, 32'd6, 32'd7, 1'b1, 64'd42);
    start = 1'b1;
    begin
      int edges = 0;
      do begin
        op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
        @(posedge clk); #1;
        edges++;
      end while (!HiWrite && edges < 40);
      chk("repulse_latency", 64'(edges), 64'd32);
    end
    op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    @(posedge clk); #1;
    chk("repulse_busy_down", {63'd0, busy}, 64'd0);
    run_op("b2b", DIV, 32'hFFFFFF9C, 32'd7, model(DIV, 32'hFFFFFF9C, 32'd7));

    // cancel in IDLE is ignored and start is still accepted
    cancel = 1'b1;
    issue("idle_cancel", MULT, 32'd1000, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFF_FFFFF830);
    cancel = 1'b0;
    wait_strobe("idle_cancel");
    finish_op("idle_cancel");

    // cancel after step 10: no strobe, outputs keep the previous result
    issue("cancel", MULTU, 32'd9, 32'd9, 1'b0, 64'd0);
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_strobe", {62'd0, HiWrite, LoWrite}, 64'd0);
    chk("cancel_hold", {hi_data_in, lo_data_in}, last_res);
    repeat (40) @(posedge clk);
    #1 chk("cancel_hold_late", {hi_data_in, lo_data_in}, last_res);

    // reset at step 20 clears everything at once
    issue("reset_mid", DIVU, 32'd12345, 32'd3, 1'b0, 64'd0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_data", {hi_data_in, lo_data_in}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("rst_mid_no_strobe", {hi_data_in, lo_data_in}, 64'd0);
    run_op("post_rst_3x5", MULTU, 32'd3, 32'd5, 64'd15);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
